// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage.
//   pipe_state_e : stage occupancy states (EMPTY / ONE / FULL)
//   PIPE_NOP     : nop payload, truncated/extended to WIDTH as the default bubble
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [63:0] PIPE_NOP = 64'h0;

endpackage : pipe_pkg

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one stage entry (valid bit + WIDTH-bit payload).
// Ports:
//   clk, reset_n    : rising-edge clock, synchronous active-low reset
//   load, load_data : capture load_data and mark the entry valid
//   clear           : empty the entry and park the bubble payload (wins over load)
//   valid, data     : registered entry contents
// With neither load nor clear the entry holds.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(PIPE_NOP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Next entry contents: clear beats load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_VALUE;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Entry register with synchronous reset to the empty/bubble state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule : pipe_entry_reg

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register carrying an
// opaque WIDTH-bit payload between pipeline stages.
// Build option: PIPE_SKID_EN
//   defined   : head entry M plus skid entry S, in_ready = reset_n & !S.valid
//               (no path from out_ready), occupancy 0..2
//   undefined : head entry M only, in_ready = reset_n & (!M.valid | out_ready)
// Ports:
//   clk, reset_n         : rising-edge clock, synchronous active-low reset
//   flush                : empty all entries; same-cycle input is dropped
//   in_valid/in_ready    : upstream handshake, in_data payload
//   out_valid/out_ready  : downstream handshake, out_data = head payload
//                          (BUBBLE_VALUE when empty)
//   occupancy            : number of entries held
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(PIPE_NOP)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_load;
  logic             m_clear;
  logic [WIDTH-1:0] m_din;
  logic             in_fire;
  logic             out_fire;
  pipe_state_e      cur_state;

  pipe_entry_reg #(
    .WIDTH        (WIDTH),
    .BUBBLE_VALUE (BUBBLE_VALUE)
  ) u_m_entry (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (m_load),
    .clear     (m_clear),
    .load_data (m_din),
    .valid     (m_valid),
    .data      (m_data)
  );

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_load;
  logic             s_clear;

  pipe_entry_reg #(
    .WIDTH        (WIDTH),
    .BUBBLE_VALUE (BUBBLE_VALUE)
  ) u_s_entry (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (s_load),
    .clear     (s_clear),
    .load_data (in_data),
    .valid     (s_valid),
    .data      (s_data)
  );

  // Ready depends only on the skid flop, so upstream sees no path from out_ready.
  assign in_ready  = reset_n & ~s_valid;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  // Current state decoded from the entry valid flags (S is only ever filled behind M).
  always_comb begin
    if (s_valid) begin
      cur_state = PS_FULL;
    end else if (m_valid) begin
      cur_state = PS_ONE;
    end else begin
      cur_state = PS_EMPTY;
    end
  end

  // Entry control: flush empties both, otherwise advance per state and handshakes.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    m_din   = in_data;
    s_load  = 1'b0;
    s_clear = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      case (cur_state)
        PS_EMPTY: begin
          if (in_fire) begin
            m_load = 1'b1;
          end else begin
            m_load = 1'b0;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            m_load = 1'b1;
          end else if (in_fire) begin
            // Head is stalled: park the new payload in the skid entry.
            s_load = 1'b1;
          end else if (out_fire) begin
            m_clear = 1'b1;
          end else begin
            m_load = 1'b0;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            // Skid payload moves up to the head; skid goes back to bubble.
            m_load  = 1'b1;
            m_din   = s_data;
            s_clear = 1'b1;
          end else begin
            m_load = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: drain to a known empty state.
          m_clear = 1'b1;
          s_clear = 1'b1;
        end
      endcase
    end
  end
`else
  // Single entry: a stalled head can be replaced in place when it leaves this cycle.
  assign in_ready  = reset_n & (~m_valid | out_ready);
  assign occupancy = {1'b0, m_valid};

  // Current state decoded from the head valid flag.
  always_comb begin
    if (m_valid) begin
      cur_state = PS_ONE;
    end else begin
      cur_state = PS_EMPTY;
    end
  end

  // Entry control: flush empties the head, otherwise load on input or drain on output.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    m_din   = in_data;
    if (flush) begin
      m_clear = 1'b1;
    end else begin
      case (cur_state)
        PS_EMPTY: begin
          if (in_fire) begin
            m_load = 1'b1;
          end else begin
            m_load = 1'b0;
          end
        end
        PS_ONE: begin
          if (in_fire) begin
            m_load = 1'b1;
          end else if (out_fire) begin
            m_clear = 1'b1;
          end else begin
            m_load = 1'b0;
          end
        end
        default: begin
          m_clear = 1'b1;
        end
      endcase
    end
  end
`endif

endmodule : pipe_stage_elastic
